// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RISC-V memory arbiter slice.
//   arb_state_e    - arbiter FSM states (IDLE, IBUS, DBUS, IDISCARD)
//   BUS_*          - bus completion codes (ok, error, timeout)
//   TIMER_W        - wait counter width, wide enough for TIMEOUT up to 1023
//   bus_code()     - classifies a bus cycle outcome into a completion code
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IBUS     = 2'd1,
    DBUS     = 2'd2,
    IDISCARD = 2'd3
  } arb_state_e;

  localparam logic [1:0] BUS_OK      = 2'b00;
  localparam logic [1:0] BUS_ERR     = 2'b01;
  localparam logic [1:0] BUS_TIMEOUT = 2'b10;

  localparam int TIMER_W = 10;

  // An error completion wins over a plain ack (both asserted counts as an
  // error); a timeout only applies when the slave gave no completion at all.
  function automatic logic [1:0] bus_code(input logic ack, input logic err,
                                          input logic expired);
    logic [1:0] code;
    if (err) begin
      code = BUS_ERR;
    end else if (ack) begin
      code = BUS_OK;
    end else if (expired) begin
      code = BUS_TIMEOUT;
    end else begin
      code = BUS_OK;
    end
    return code;
  endfunction

endpackage

// File: rtl/riscv_mem_arb_timer.sv
// riscv_mem_arb_timer: bus wait counter for the memory arbiter.
//   clk, rstn - clock, asynchronous active-low reset
//   clr       - clears the counter (asserted on every grant)
//   busy      - a bus transaction is outstanding this cycle
//   expired   - this busy cycle is the TIMEOUT-th one since the grant
module riscv_mem_arb_timer
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic busy,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt_r;

  // Wait counter: cleared at grant, counts every busy cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (busy) begin
      cnt_r <= cnt_r + 10'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // cnt_r holds the number of busy cycles already completed, so the current
  // busy cycle is the TIMEOUT-th one when cnt_r equals TIMEOUT-1.
  assign expired = busy && (cnt_r == LAST);

endmodule

// File: rtl/riscv_mem_arb.sv
// riscv_mem_arb: arbitrates an instruction-fetch port and a data port onto a
// single bus with one outstanding transaction.
//   clk, rstn                       - clock, asynchronous active-low reset
//   i_req/i_adr/i_flush             - fetch request, address, flush
//   i_gnt/i_rvalid/i_rdata/i_radr/i_err - fetch grant and response
//   d_req/d_we/d_be/d_adr/d_wdata   - data request
//   d_gnt/d_rvalid/d_err/d_rdata    - data grant and response
//   m_req/m_we/m_be/m_adr/m_wdata   - registered bus request
//   m_ack/m_err/m_rdata             - bus completion
// Data normally wins, but after MAX_DSTREAK consecutive data grants with a
// fetch waiting, the fetch is served next.
module riscv_mem_arb
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT     = 255,
  parameter int MAX_DSTREAK = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_adr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  output logic [XLEN-1:0]   i_radr,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN/8-1:0] d_be,
  input  logic [XLEN-1:0]   d_adr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_err,
  output logic [XLEN-1:0]   d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [XLEN/8-1:0] m_be,
  output logic [XLEN-1:0]   m_adr,
  output logic [XLEN-1:0]   m_wdata,
  input  logic              m_ack,
  input  logic              m_err,
  input  logic [XLEN-1:0]   m_rdata
);

  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_e         state_r, state_s;
  logic [SW-1:0]      dstreak_r;
  logic               m_req_r, m_we_r;
  logic [XLEN/8-1:0]  m_be_r;
  logic [XLEN-1:0]    m_adr_r, m_wdata_r;
  logic               busy_s, done_s, expired_s, grant_s;
  logic [1:0]         code_s;
  logic [XLEN-1:0]    rsp_data_s;

  assign busy_s     = (state_r != IDLE);
  assign done_s     = m_ack | m_err | expired_s;
  assign code_s     = bus_code(m_ack, m_err, expired_s);
  // A timed-out transaction never saw slave data, so return zero.
  assign rsp_data_s = (code_s == BUS_TIMEOUT) ? '0 : m_rdata;
  assign grant_s    = d_gnt | i_gnt;

  assign m_req   = m_req_r;
  assign m_we    = m_we_r;
  assign m_be    = m_be_r;
  assign m_adr   = m_adr_r;
  assign m_wdata = m_wdata_r;

  riscv_mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (grant_s),
    .busy    (busy_s),
    .expired (expired_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, combinational grants and same-cycle responses. Grants are
  // gated by rstn so that nothing is accepted while reset is held.
  always_comb begin
    state_s  = state_r;
    d_gnt    = 1'b0;
    i_gnt    = 1'b0;
    d_rvalid = 1'b0;
    d_err    = 1'b0;
    d_rdata  = '0;
    i_rvalid = 1'b0;
    i_err    = 1'b0;
    i_rdata  = '0;
    i_radr   = '0;
    case (state_r)
      IDLE: begin
        if (rstn && d_req && ((dstreak_r < STREAK_MAX) || !i_req)) begin
          d_gnt   = 1'b1;
          state_s = DBUS;
        end else if (rstn && i_req && !i_flush) begin
          i_gnt   = 1'b1;
          state_s = IBUS;
        end else begin
          state_s = IDLE;
        end
      end
      DBUS: begin
        if (done_s) begin
          d_rvalid = 1'b1;
          d_err    = (code_s != BUS_OK);
          d_rdata  = rsp_data_s;
          state_s  = IDLE;
        end else begin
          state_s  = DBUS;
        end
      end
      IBUS: begin
        if (done_s) begin
          // A flush in the completion cycle swallows the response.
          if (!i_flush) begin
            i_rvalid = 1'b1;
            i_err    = (code_s != BUS_OK);
            i_rdata  = rsp_data_s;
            i_radr   = m_adr_r;
          end else begin
            i_rvalid = 1'b0;
          end
          state_s = IDLE;
        end else if (i_flush) begin
          state_s = IDISCARD;
        end else begin
          state_s = IBUS;
        end
      end
      IDISCARD: begin
        if (done_s) begin
          state_s = IDLE;
        end else begin
          state_s = IDISCARD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Bus request registers: loaded at grant, held until completion/timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_req_r   <= 1'b0;
      m_we_r    <= 1'b0;
      m_be_r    <= '0;
      m_adr_r   <= '0;
      m_wdata_r <= '0;
    end else if (d_gnt) begin
      m_req_r   <= 1'b1;
      m_we_r    <= d_we;
      m_be_r    <= d_be;
      m_adr_r   <= d_adr;
      m_wdata_r <= d_wdata;
    end else if (i_gnt) begin
      m_req_r   <= 1'b1;
      m_we_r    <= 1'b0;
      m_be_r    <= '1;
      m_adr_r   <= i_adr;
      m_wdata_r <= '0;
    end else if (busy_s && done_s) begin
      m_req_r   <= 1'b0;
    end else begin
      m_req_r   <= m_req_r;
    end
  end

  // Data streak: counts data grants that bypassed a waiting fetch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dstreak_r <= '0;
    end else if (!i_req || i_gnt) begin
      dstreak_r <= '0;
    end else if (d_gnt && (dstreak_r < STREAK_MAX)) begin
      dstreak_r <= dstreak_r + 1'b1;
    end else begin
      dstreak_r <= dstreak_r;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arb.sv
// tb_riscv_mem_arb: scoreboard bench for riscv_mem_arb.
// Address map used by the bus slave model and the reference model:
//   adr[7]=1 -> slave never answers (timeout), adr[6]=1 -> error completion
//   with rdata 0xBAD0_0000|adr, adr[9]=1 -> fetch region returning adr^0x213,
//   otherwise a 16-word RAM indexed by adr[5:2].
`timescale 1ns/1ps
module tb_riscv_mem_arb;

  localparam int XLEN = 32;
  localparam int TMO  = 8;
  localparam int MAXD = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_req, i_flush, d_req, d_we, m_ack, m_err;
  logic [31:0] i_adr, d_adr, d_wdata, m_rdata;
  logic [3:0] d_be;
  logic i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we;
  logic [31:0] i_rdata, i_radr, d_rdata, m_adr, m_wdata;
  logic [3:0] m_be;

  always #5 clk = ~clk;

  riscv_mem_arb #(.XLEN(XLEN), .TIMEOUT(TMO), .MAX_DSTREAK(MAXD)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_adr(i_adr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_radr(i_radr), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata)
  );

  typedef struct packed {logic err; logic [31:0] rdata; logic [31:0] radr;} rsp_t;
  typedef struct packed {logic [31:0] adr; logic we; logic [3:0] be; logic [31:0] wdata;} bus_t;

  rsp_t exp_d[$];
  rsp_t exp_i[$];
  bus_t cur_bus;
  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];
  byte gkind[$];
  int  gcyc[$];
  int checks = 0, passes = 0, cyc = 0;
  int fixed_lat = -1, slv_wait = -1;
  int bus_bad = 0, i_out = 0, i_rv_cnt = 0, mreq_run = 0, last_run = 0;
  int last_irv = 0, last_drv = 0;
  logic [31:0] last_irdata = 32'h0;
  logic [3:0]  last_mbe = 4'h0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Reference model: expected response of one transaction, RAM updated on
  // successful writes.
  function automatic rsp_t model(input logic we, input logic [31:0] adr,
                                 input logic [3:0] be, input logic [31:0] wd);
    rsp_t r;
    r.radr = adr;
    if (adr[7]) begin
      r.err = 1'b1; r.rdata = 32'h0;
    end else if (adr[6]) begin
      r.err = 1'b1; r.rdata = 32'hBAD0_0000 | adr;
    end else begin
      r.err = 1'b0;
      if (we) begin
        r.rdata = 32'h0;
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[adr[5:2]][8*b +: 8] = wd[8*b +: 8];
      end else if (adr[9]) begin
        r.rdata = adr ^ 32'h0000_0213;
      end else begin
        r.rdata = ref_mem[adr[5:2]];
      end
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave model.
  initial begin
    m_ack = 1'b0; m_err = 1'b0; m_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      m_ack = 1'b0; m_err = 1'b0; m_rdata = 32'h0;
      if (!rstn || !m_req) begin
        slv_wait = -1;
      end else begin
        if (slv_wait < 0)
          slv_wait = m_adr[7] ? 1000000 : ((fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3)));
        if (slv_wait == 0) begin
          if (m_adr[6]) begin
            m_err = 1'b1; m_ack = 1'($urandom_range(0, 1)); m_rdata = 32'hBAD0_0000 | m_adr;
          end else begin
            m_ack = 1'b1;
            if (m_we) begin
              for (int b = 0; b < 4; b++)
                if (m_be[b]) slv_mem[m_adr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
            end else begin
              m_rdata = m_adr[9] ? (m_adr ^ 32'h0000_0213) : slv_mem[m_adr[5:2]];
            end
          end
          slv_wait = -1;
        end else begin
          slv_wait--;
        end
      end
    end
  end

  // Monitor: logs grants, tracks bus stability, checks responses.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (d_gnt) begin gkind.push_back("D"); gcyc.push_back(cyc); end
      if (i_gnt) begin gkind.push_back("I"); gcyc.push_back(cyc); end
      if (m_req) begin
        last_mbe = m_be;
        if ({m_adr, m_we, m_be, m_wdata} !== cur_bus) bus_bad++;
        mreq_run++;
      end else if (mreq_run != 0) begin
        last_run = mreq_run; mreq_run = 0;
      end
      if (d_rvalid) begin
        last_drv = cyc;
        if (exp_d.size() == 0) begin
          checks++;
          $display("FAIL d_unexpected: d_rvalid=1 rdata=%0h with no data request outstanding", d_rdata);
        end else begin
          e = exp_d.pop_front();
          chk("d_rsp", {d_err, d_rdata}, {e.err, e.rdata});
        end
      end
      if (i_rvalid) begin
        last_irv = cyc; i_rv_cnt++; i_out = 0; last_irdata = i_rdata;
        if (exp_i.size() == 0) begin
          checks++;
          $display("FAIL i_unexpected: i_rvalid=1 radr=%0h with no fetch outstanding", i_radr);
        end else begin
          e = exp_i.pop_front();
          chk("i_rsp", {i_err, i_rdata, i_radr}, {e.err, e.rdata, e.radr});
        end
      end
    end
  end

  task automatic d_issue(input logic we, input logic [31:0] adr, input logic [3:0] be,
                         input logic [31:0] wd);
    int n = 0;
    logic got;
    d_req = 1'b1; d_we = we; d_adr = adr; d_be = be; d_wdata = wd;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk); n++; got = d_gnt;
    end
    if (got) begin
      exp_d.push_back(model(we, adr, be, wd));
      cur_bus = {adr, we, be, wd};
    end else begin
      checks++;
      $display("FAIL d_gnt_wait: no d_gnt after %0d cycles, required a grant", n);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic i_issue(input logic [31:0] adr, input int flush_after);
    int n = 0;
    logic got;
    i_req = 1'b1; i_adr = adr;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk); n++; got = i_gnt;
    end
    if (got) begin
      exp_i.push_back(model(1'b0, adr, 4'hf, 32'h0));
      cur_bus = {adr, 1'b0, 4'hf, 32'h0};
      i_out = 1;
    end else begin
      checks++;
      $display("FAIL i_gnt_wait: no i_gnt after %0d cycles, required a grant", n);
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    if (got && flush_after > 0) begin
      repeat (flush_after - 1) begin @(posedge clk); #1; end
      if (i_out != 0) begin
        i_flush = 1'b1;
        exp_i.delete(exp_i.size() - 1);
        i_out = 0;
        @(posedge clk); #1;
        i_flush = 1'b0;
      end
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_d.size() != 0 || exp_i.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    checks++;
    if (exp_d.size() == 0 && exp_i.size() == 0) passes++;
    else $display("FAIL %s_drain: pending d=%0d i=%0d, required 0", nm, exp_d.size(), exp_i.size());
    repeat (TMO + 4) @(negedge clk);
    chk({nm, "_bus_stable"}, bus_bad, 0);
    bus_bad = 0;
    @(posedge clk); #1;
  endtask

  function automatic logic [255:0] outs();
    return {i_gnt, i_rvalid, i_err, i_rdata, i_radr, d_gnt, d_rvalid, d_err, d_rdata,
            m_req, m_we, m_be, m_adr, m_wdata};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, rv0;
    string pat;
    logic [31:0] a;
    int c;
    i_req = 1'b0; i_flush = 1'b0; i_adr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_adr = 32'h0; d_wdata = 32'h0;
    cur_bus = '0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = (32'h1111_1111 * i) ^ 32'h5A5A_0000;
      slv_mem[i] = ref_mem[i];
    end
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 256'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single fetch, slave acks in the fourth cycle after the grant.
    fixed_lat = 3; n0 = gkind.size();
    i_issue(32'h0000_0200, 0);
    drain("fetch_lat");
    chk("fetch_gnt_kind", gkind[n0], "I");
    chk("fetch_rsp_cycle", last_irv - gcyc[n0], 4);
    chk("fetch_rdata", last_irdata, 32'h0000_0013);

    // Both ports held continuously: two data grants, then a fetch.
    fixed_lat = -1; n0 = gkind.size();
    fork
      begin for (int k = 0; k < 6; k++) d_issue(1'b0, 32'(k * 4), 4'hf, 32'h0); end
      begin for (int k = 0; k < 2; k++) i_issue(32'h0000_0200 + 32'(k * 4), 0); end
    join
    drain("order");
    pat = "DDIDDI";
    for (int k = 0; k < 6; k++) chk("grant_order", gkind[n0 + k], pat[k]);

    // Flush one cycle before the ack; data waiting in discard.
    fixed_lat = 3; n0 = gkind.size(); rv0 = i_rv_cnt;
    fork
      i_issue(32'h0000_0204, 3);
      begin repeat (3) begin @(posedge clk); #1; end d_issue(1'b0, 32'h0000_0008, 4'hf, 32'h0); end
    join
    drain("flush");
    chk("flush_no_irvalid", i_rv_cnt - rv0, 0);
    chk("flush_order", {gkind[n0], gkind[n0 + 1]}, {8'h49, 8'h44});
    chk("flush_dgnt_cycle", gcyc[n0 + 1] - gcyc[n0], 5);

    // Data read that the slave never answers.
    fixed_lat = -1; n0 = gkind.size();
    d_issue(1'b0, 32'h0000_0080, 4'hf, 32'h0);
    drain("timeout");
    chk("timeout_mreq_cycles", last_run, TMO);
    chk("timeout_rsp_cycle", last_drv - gcyc[n0], TMO);

    // Partial write completing with an error.
    d_issue(1'b1, 32'h0000_0044, 4'b0011, 32'hCAFE_F00D);
    drain("write_err");
    chk("write_err_mbe", last_mbe, 4'b0011);

    // Reset in the middle of a fetch.
    fixed_lat = 5; rv0 = i_rv_cnt;
    i_issue(32'h0000_0208, 0);
    @(posedge clk); #3;
    rstn = 1'b0; d_req = 1'b1; i_req = 1'b1;
    #1;
    chk("reset_midtxn_outputs", outs(), 256'h0);
    exp_i.delete(); i_out = 0;
    @(posedge clk); #1;
    d_req = 1'b0; i_req = 1'b0; rstn = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("reset_no_irvalid", i_rv_cnt - rv0, 0);

    // Randomised mix of reads, writes, fetches, errors, timeouts and flushes.
    fixed_lat = -1;
    fork
      begin
        logic [31:0] da;
        int dc;
        for (int k = 0; k < 40; k++) begin
          dc = int'($urandom_range(0, 9));
          da = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          if (dc == 0) da[6] = 1'b1;
          else if (dc == 1) da[7] = 1'b1;
          if ($urandom_range(0, 1) == 1)
            d_issue(1'b1, da, 4'($urandom_range(1, 15)), $urandom);
          else
            d_issue(1'b0, da, 4'hf, 32'h0);
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          c = int'($urandom_range(0, 9));
          a = 32'h0000_0200 | {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          if (c == 0) a[6] = 1'b1;
          else if (c == 1) a[7] = 1'b1;
          i_issue(a, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join
    drain("random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arb.md
RISCV_MEM_ARB -- requirements
Module: riscv_mem_arb

Interface
REQ-001 Parameter XLEN, default 32: address and data width.
REQ-002 Parameter TIMEOUT, default 255: bus wait cycles before abort; range 1..1023.
REQ-003 Parameter MAX_DSTREAK, default 2: consecutive data grants allowed while an instruction request waits.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 i_req  input  1  fetch request, held until i_gnt.
REQ-007 i_adr  input  XLEN  fetch address.
REQ-008 i_flush  input  1  fetch flush; discards the pending or in-flight fetch.
REQ-009 i_gnt  output  1  fetch address accepted.
REQ-010 i_rvalid  output  1  fetch response valid, one cycle.
REQ-011 i_rdata  output  XLEN  fetch response data.
REQ-012 i_radr  output  XLEN  address of the returned fetch.
REQ-013 i_err  output  1  fetch bus error or timeout, qualified by i_rvalid.
REQ-014 d_req, d_we  input  1 each  data request, held until d_gnt; d_we=1 is a write.
REQ-015 d_be  input  XLEN/8  byte enables.
REQ-016 d_adr, d_wdata  input  XLEN each  data address and write data.
REQ-017 d_gnt, d_rvalid, d_err  output  1 each  data grant, response valid, error.
REQ-018 d_rdata  output  XLEN  data read result.
REQ-019 m_req, m_we  output  1 each  bus request and write strobe.
REQ-020 m_be  output  XLEN/8  bus byte enables.
REQ-021 m_adr, m_wdata  output  XLEN each  bus address and write data.
REQ-022 m_ack, m_err  input  1 each  bus completion and error completion.
REQ-023 m_rdata  input  XLEN  bus read data.

Function
REQ-024 FSM states: IDLE, IBUS, DBUS, IDISCARD; one bus transaction outstanding at a time.
REQ-025 In IDLE, with d_req=1 and dstreak<MAX_DSTREAK, or with d_req=1 and i_req=0: issue d_gnt=1 (combinational, same cycle), latch d_* into bus registers, go to DBUS.
REQ-026 In IDLE, otherwise with i_req=1 and i_flush=0: issue i_gnt=1, latch i_adr, go to IBUS; a grant to data or fetch occurs only in IDLE.
REQ-027 dstreak increments on each data grant while i_req=1, clears on each instruction grant or when i_req=0, and saturates at MAX_DSTREAK.
REQ-028 m_req=1 and m_adr/m_we/m_be/m_wdata are registered and stable from the cycle after the grant until the m_ack or m_err cycle inclusive.
REQ-029 On m_ack or m_err in DBUS: d_rvalid=1 in the same cycle, d_rdata=m_rdata, d_err=m_err, then go to IDLE; writes also pulse d_rvalid.
REQ-030 On m_ack or m_err in IBUS: i_rvalid=1, i_rdata=m_rdata, i_radr=latched address, i_err=m_err, then go to IDLE.
REQ-031 When i_flush=1 in IBUS and no completion arrives that cycle, go to IDISCARD; a later completion is absorbed with i_rvalid=0, then go to IDLE.
REQ-032 When i_flush=1 and the completion arrives in the same cycle, i_rvalid=0 and go to IDLE.
REQ-033 When i_flush=1 in IDLE, i_gnt=0 that cycle.
REQ-034 A wait counter clears at each grant and increments each busy cycle.
REQ-035 When the wait counter reaches TIMEOUT with no completion, drop m_req, return the response with err=1 and rdata=0 (suppressed in IDISCARD), and go to IDLE.
REQ-036 m_ack and m_err outside a busy state are ignored.
REQ-037 A completion with both m_ack and m_err asserted is treated as an error.
REQ-038 IDLE to the next grant takes zero idle cycles, so back-to-back transactions are legal.

Reset
REQ-039 Asynchronous reset sets state=IDLE; dstreak=0; wait counter=0; m_req=0; m_we=0; m_be=0; m_adr=0; m_wdata=0.
REQ-040 Asynchronous reset sets every response output to 0: i_gnt, i_rvalid, i_err, i_rdata, i_radr, d_gnt, d_rvalid, d_err, d_rdata.
REQ-041 Reset mid-transaction abandons the transaction without any response.

Structure
REQ-042 The state enum and the bus-error-code constants reside in riscv_pkg.
REQ-043 One sub-module, riscv_mem_arb_timer, implements the wait counter.
REQ-044 The design contains no other hierarchy.

Verification
REQ-045 i_req=1 at 0x200, m_ack after 3 cycles with m_rdata=0x00000013 -> i_gnt in cycle 0, i_rvalid with i_radr=0x200 and i_rdata=0x13 in cycle 4.
REQ-046 i_req and d_req both held continuously with MAX_DSTREAK=2 -> grant order D,D,I,D,D,I.
REQ-047 Fetch in flight with i_flush pulsed one cycle before m_ack -> no i_rvalid; a data request pending during the discard is granted the cycle after the ack.
REQ-048 Data read with no m_ack and TIMEOUT=8 -> m_req drops after 8 cycles, d_rvalid=1, d_err=1, d_rdata=0.
REQ-049 Write with d_be=4'b0011 and m_err on completion -> m_be=4'b0011 stable during the whole request, d_err=1.
REQ-050 rstn asserted during IBUS -> all outputs 0 immediately and no i_rvalid after reset release.
